// File: rtl/clint.sv
// CLINT: msip / mtimecmp / mtime MMIO registers and interrupt levels for the trap unit.
// Define CLINT_PRESCALER_EN to divide the mtime tick by TICK_DIV.
package riscv_pkg;
    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } interrupt_t;
endpackage

module clint #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [15:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    input  logic [3:0]            i_req_wstrb,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    input  logic                  i_ext_irq,
    output riscv_pkg::interrupt_t o_interrupts
);
    localparam int unsigned AW = 14;
    localparam logic [AW-1:0] A_MSIP    = 14'h0000;
    localparam logic [AW-1:0] A_CMP_LO  = 14'h1000;
    localparam logic [AW-1:0] A_CMP_HI  = 14'h1001;
    localparam logic [AW-1:0] A_TIME_LO = 14'h2FFE;
    localparam logic [AW-1:0] A_TIME_HI = 14'h2FFF;

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          mtip_q, mtip_d;
    logic [1:0]    sync_q, sync_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          accept, wr, hit, tick, time_wr;
    logic [AW-1:0] word;
    logic [31:0]   rd_val;
    logic          unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // Responses never stall, so a new request is taken every cycle outside reset.
    assign o_req_ready = i_rst_n;
    assign accept      = i_req_valid & o_req_ready;
    assign word        = i_req_addr[15:2];
    assign wr          = accept & i_req_we & hit;
    assign unused_bits = ^{16'(TICK_DIV), i_req_addr[1:0]};

    always_comb begin
        hit    = 1'b1;
        rd_val = '0;
        case (word)
            A_MSIP:    rd_val = {31'b0, msip_q};
            A_CMP_LO:  rd_val = mtimecmp_q[31:0];
            A_CMP_HI:  rd_val = mtimecmp_q[63:32];
            A_TIME_LO: rd_val = mtime_q[31:0];
            A_TIME_HI: rd_val = mtime_q[63:32];
            default:   hit    = 1'b0;
        endcase
    end

`ifdef CLINT_PRESCALER_EN
    logic [15:0] presc_q, presc_d;

    assign tick = (presc_q == 16'(TICK_DIV - 1));

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        if (time_wr) presc_d = 16'd0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) presc_q <= 16'd0;
        else          presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    // Register writes; an mtime write replaces that cycle's increment for both halves.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        time_wr    = 1'b0;
        if (wr) begin
            case (word)
                A_MSIP:   if (i_req_wstrb[0]) msip_d = i_req_wdata[0];
                A_CMP_LO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], i_req_wdata, i_req_wstrb);
                A_CMP_HI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], i_req_wdata, i_req_wstrb);
                A_TIME_LO: if (|i_req_wstrb) begin
                    mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], i_req_wdata, i_req_wstrb)};
                    time_wr = 1'b1;
                end
                A_TIME_HI: if (|i_req_wstrb) begin
                    mtime_d = {merge(mtime_q[63:32], i_req_wdata, i_req_wstrb), mtime_q[31:0]};
                    time_wr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept & ~hit;
        rsp_rdata_d = (accept & ~i_req_we & hit) ? rd_val : 32'd0;
        mtip_d      = (mtime_q >= mtimecmp_q);
        sync_d      = {sync_q[0], i_ext_irq};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RST;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            sync_q      <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            sync_q      <= sync_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_interrupts = {sync_q[1], mtip_q, msip_q};
endmodule

// File: tb/tb_clint.sv
// Bench for clint: cycle-level reference model plus directed MMIO / interrupt scenarios.
module tb_clint;
    localparam int unsigned TB_TICK_DIV = 4;
    localparam logic [63:0] CMP_RST     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, ext_irq = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    riscv_pkg::interrupt_t irqs;

    int n_checks = 0;
    int n_fail   = 0;

    clint #(.TICK_DIV(TB_TICK_DIV), .MTIMECMP_RST(CMP_RST)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_wstrb(req_wstrb), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .i_ext_irq(ext_irq), .o_interrupts(irqs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    // Reference model: architectural registers updated once per clock edge.
    logic [63:0] m_mtime = '0, m_cmp = CMP_RST;
    logic        m_msip = 1'b0, m_irq_prev = 1'b0;
    int unsigned m_presc = 0;
    logic        e_valid = 1'b0, e_err = 1'b0, e_mtip = 1'b0, e_msip = 1'b0, e_meip = 1'b0;
    logic [31:0] e_rdata = '0;

    always @(posedge clk) begin
        logic [15:0] a;
        logic        hit, time_wr;
        if (!rst_n) begin
            m_mtime = '0; m_cmp = CMP_RST; m_msip = 1'b0; m_presc = 0; m_irq_prev = 1'b0;
            e_valid = 1'b0; e_err = 1'b0; e_rdata = '0;
            e_mtip = 1'b0; e_msip = 1'b0; e_meip = 1'b0;
        end else begin
            e_mtip     = (m_mtime >= m_cmp);
            e_meip     = m_irq_prev;
            m_irq_prev = ext_irq;
            e_valid    = req_valid;
            e_err      = 1'b0;
            e_rdata    = '0;
            time_wr    = 1'b0;
            if (req_valid) begin
                a     = req_addr & 16'hFFFC;
                hit   = a inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
                e_err = !hit;
                if (!req_we) begin
                    case (a)
                        16'h0000: e_rdata = {31'b0, m_msip};
                        16'h4000: e_rdata = m_cmp[31:0];
                        16'h4004: e_rdata = m_cmp[63:32];
                        16'hBFF8: e_rdata = m_mtime[31:0];
                        16'hBFFC: e_rdata = m_mtime[63:32];
                        default:  e_rdata = '0;
                    endcase
                end else begin
                    case (a)
                        16'h0000: if (req_wstrb[0]) m_msip = req_wdata[0];
                        16'h4000: m_cmp[31:0]  = lanes(m_cmp[31:0], req_wdata, req_wstrb);
                        16'h4004: m_cmp[63:32] = lanes(m_cmp[63:32], req_wdata, req_wstrb);
                        16'hBFF8: if (req_wstrb != 0) begin
                            m_mtime[31:0] = lanes(m_mtime[31:0], req_wdata, req_wstrb);
                            time_wr = 1'b1;
                        end
                        16'hBFFC: if (req_wstrb != 0) begin
                            m_mtime[63:32] = lanes(m_mtime[63:32], req_wdata, req_wstrb);
                            time_wr = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
`ifdef CLINT_PRESCALER_EN
            if (time_wr) m_presc = 0;
            else begin
                m_presc++;
                if (m_presc == TB_TICK_DIV) begin
                    m_presc = 0;
                    m_mtime = m_mtime + 64'd1;
                end
            end
`else
            if (!time_wr) m_mtime = m_mtime + 64'd1;
`endif
            e_msip = m_msip;
        end
    end

    // Every-cycle comparison against the model, mid-period.
    always @(negedge clk) begin
        check("req_ready", 64'(req_ready), 64'(rst_n));
        check("rsp_valid", 64'(rsp_valid), 64'(e_valid));
        if (e_valid) begin
            check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
            check("rsp_err", 64'(rsp_err), 64'(e_err));
        end
        check("mtip", 64'(irqs.mtip), 64'(e_mtip));
        check("msip", 64'(irqs.msip), 64'(e_msip));
        check("meip", 64'(irqs.meip), 64'(e_meip));
    end

    task automatic req(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err);
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
        @(posedge clk); #2;
        req_valid = 1'b0; req_we = 1'b0; req_wstrb = '0;
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        req(1'b0, addr, '0, '0, rd, err);
        check(name, 64'(rd), 64'(exp));
        check({name, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] rd;
        logic        err;
        req(1'b1, addr, wd, st, rd, err);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, got;
        int          first, cnt;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        req(1'b0, 16'hBFF8, '0, '0, rd, err);
        check("mtime_lo_small", 64'(rd < 32'd16), 64'd1);
        check("mtime_lo_err", 64'(err), 64'd0);
        rd_chk("cmp_hi_rst", 16'h4004, 32'hFFFF_FFFF);
        rd_chk("msip_rst", 16'h0000, 32'h0);

        // mtip rises once mtime reaches mtimecmp = 20.
        wr(16'hBFF8, 32'd0, 4'hF);
        wr(16'h4004, 32'd0, 4'hF);
        wr(16'h4000, 32'd20, 4'hF);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (irqs.mtip) begin
                got = 1'b1;
                break;
            end
        end
        check("mtip_rise_seen", 64'(got), 64'd1);
`ifndef CLINT_PRESCALER_EN
        rd_chk("mtime_after_rise", 16'hBFF8, 32'd22);
`endif
        wr(16'h4004, 32'd1, 4'hF);
        check("mtip_hold", 64'(irqs.mtip), 64'd1);
        @(posedge clk); #2;
        check("mtip_fall", 64'(irqs.mtip), 64'd0);

        // Partial-lane write and ignored address bits.
        wr(16'h4000, 32'h0000_AB00, 4'h2);
        rd_chk("cmp_lo_lane", 16'h4000, 32'h0000_AB14);
        rd_chk("cmp_hi_addr_lsb", 16'h4006, 32'd1);

        // mtime wrap through 2^64-1.
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
`ifdef CLINT_PRESCALER_EN
        rd_chk("wrap_lo", 16'hBFF8, 32'hFFFF_FFFF);
        rd_chk("wrap_hi", 16'hBFFC, 32'hFFFF_FFFF);
        rd_chk("wrap_lo_later", 16'hBFF8, 32'd0);
`else
        rd_chk("wrap_lo", 16'hBFF8, 32'd0);
        rd_chk("wrap_hi", 16'hBFFC, 32'd0);
        rd_chk("wrap_lo_later", 16'hBFF8, 32'd4);
`endif

        // msip bit-0 semantics and strobe-less writes.
        wr(16'h0000, 32'h3, 4'h1);
        check("msip_set", 64'(irqs.msip), 64'd1);
        rd_chk("msip_read", 16'h0000, 32'h1);
        wr(16'h0000, 32'h0, 4'h0);
        check("msip_wstrb0", 64'(irqs.msip), 64'd1);
        wr(16'h0000, 32'h0, 4'h1);
        check("msip_clr", 64'(irqs.msip), 64'd0);

        // Unmapped accesses.
        req(1'b0, 16'h2000, '0, '0, rd, err);
        check("unmapped_rd_err", 64'(err), 64'd1);
        check("unmapped_rd_data", 64'(rd), 64'd0);
        req(1'b1, 16'h2000, 32'hFFFF_FFFF, 4'hF, rd, err);
        check("unmapped_wr_err", 64'(err), 64'd1);
        req(1'b1, 16'h4008, 32'hFFFF_FFFF, 4'hF, rd, err);
        check("unmapped_wr2_err", 64'(err), 64'd1);
        rd_chk("msip_untouched", 16'h0000, 32'h0);
        rd_chk("cmp_hi_untouched", 16'h4004, 32'd1);

        // External interrupt: 5-cycle pulse through the synchronizer.
        @(posedge clk); #2;
        ext_irq = 1'b1;
        first = -1;
        cnt   = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (irqs.meip) begin
                cnt++;
                if (first < 0) first = i;
            end
            if (i == 4) ext_irq = 1'b0;
        end
        check("meip_delay", 64'(first), 64'd1);
        check("meip_width", 64'(cnt), 64'd5);

        // Request presented while reset asserts is dropped.
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4004;
        rst_n = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        check("rst_drop", 64'(rsp_valid), 64'd0);
        check("rst_mtip", 64'(irqs.mtip), 64'd0);
        rst_n = 1'b1;
        rd_chk("cmp_hi_rst2", 16'h4004, 32'hFFFF_FFFF);
        rd_chk("cmp_lo_rst2", 16'h4000, 32'hFFFF_FFFF);

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
